// File: rtl/serial_pkg.sv
// Shared serial-path definitions: FSM state encoding used by the serializer
// and the downstream sequence-detector stages.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_GAP   = 2'b10
    } state_t;

    localparam int unsigned GAP_CNT_W = 4;

endpackage

// File: rtl/seq_serializer.sv
// Parallel-to-serial converter: captures a WIDTH-bit word and emits it one bit
// per cycle on x, with optional idle gap cycles after each word.
module seq_serializer
    import serial_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned MSB_FIRST = 1,
    parameter int unsigned GAP       = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]     CNT_LAST = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0]     CNT_PEN  = CNT_W'(WIDTH - 2);
    localparam logic [GAP_CNT_W-1:0] GAP_LAST = GAP_CNT_W'((GAP > 0) ? GAP - 1 : 0);

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [GAP_CNT_W-1:0] gcnt_q, gcnt_d;
    logic [WIDTH-1:0]     sreg_q, sreg_d;
    logic                 x_d, x_valid_d, last_d, busy_d;
    logic                 accept;

    // Bit presented next, and the word with that bit consumed.
    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign din_ready = (state_q == ST_IDLE) ||
                       ((GAP == 0) && (state_q == ST_SHIFT) && (cnt_q == CNT_LAST));
    assign accept    = din_valid && din_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gcnt_q  <= '0;
            sreg_q  <= '0;
            x       <= 1'b0;
            x_valid <= 1'b0;
            last    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gcnt_q  <= gcnt_d;
            sreg_q  <= sreg_d;
            x       <= x_d;
            x_valid <= x_valid_d;
            last    <= last_d;
            busy    <= busy_d;
        end
    end

    // Next state and next registered outputs; the first bit is driven on the
    // accept edge itself so it appears one cycle after acceptance.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        gcnt_d    = gcnt_q;
        sreg_d    = sreg_q;
        x_d       = 1'b0;
        x_valid_d = 1'b0;
        last_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = '0;
                    x_d       = head(din);
                    sreg_d    = advance(din);
                    x_valid_d = 1'b1;
                end
            end
            ST_SHIFT: begin
                if (cnt_q != CNT_LAST) begin
                    cnt_d     = cnt_q + CNT_W'(1);
                    x_d       = head(sreg_q);
                    sreg_d    = advance(sreg_q);
                    x_valid_d = 1'b1;
                    last_d    = (cnt_q == CNT_PEN);
                end else begin
                    cnt_d = '0;
                    if (GAP > 0) begin
                        state_d = ST_GAP;
                        gcnt_d  = '0;
                    end else if (accept) begin
                        state_d   = ST_SHIFT;
                        x_d       = head(din);
                        sreg_d    = advance(din);
                        x_valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                if (gcnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    gcnt_d  = '0;
                end else begin
                    gcnt_d = gcnt_q + GAP_CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                gcnt_d  = '0;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

endmodule

// File: tb/tb_seq_serializer.sv
// Randomized scoreboard bench for seq_serializer: instance 0 is MSB-first with
// no gap, instance 1 is LSB-first with a two-cycle gap.
module tb_seq_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din       [2];
    logic         din_valid [2];
    logic         din_ready [2];
    logic         x         [2];
    logic         x_valid   [2];
    logic         last      [2];
    logic         busy      [2];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input int inst,
                         input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, inst, $time, act, exp);
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int unsigned MSB = (g == 0) ? 1 : 0;
        localparam int unsigned GP  = (g == 0) ? 0 : 2;

        seq_serializer #(.WIDTH(W), .MSB_FIRST(MSB), .GAP(GP)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .din       (din[g]),
            .din_valid (din_valid[g]),
            .din_ready (din_ready[g]),
            .x         (x[g]),
            .x_valid   (x_valid[g]),
            .last      (last[g]),
            .busy      (busy[g])
        );

        // Reference: queue of expected {bit,last} plus cycles until the block is free.
        logic [1:0] q[$];
        int         busy_m = 0;
        logic [1:0] e;
        bit         ready_m;

        always @(posedge rst) begin
            q.delete();
            busy_m = 0;
        end

        always @(negedge clk) begin
            if (rst !== 1'b1) begin
                if (x_valid[g]) begin
                    if (q.size() == 0) check("unexpected_bit", g, 32'(x_valid[g]), 0);
                    else begin
                        e = q.pop_front();
                        check("x", g, 32'(x[g]), 32'(e[1]));
                        check("last", g, 32'(last[g]), 32'(e[0]));
                    end
                end else begin
                    check("idle_x_last", g, {30'd0, x[g], last[g]}, 0);
                    check("bubble", g, q.size(), 0);
                end
                ready_m = (busy_m == 0) || (GP == 0 && busy_m == 1);
                check("din_ready", g, 32'(din_ready[g]), 32'(ready_m));
                check("busy", g, 32'(busy[g]), 32'(busy_m > 0));
                if (din_valid[g] && ready_m) begin
                    for (int i = 0; i < int'(W); i++)
                        q.push_back({din[g][(MSB != 0) ? int'(W) - 1 - i : i], i == int'(W) - 1});
                    busy_m = int'(W + GP);
                end else if (busy_m > 0) begin
                    busy_m--;
                end
            end
        end
    end

    task automatic set(input int g, input logic [W-1:0] d, input logic v);
        din[g]       = d;
        din_valid[g] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        set(0, '0, 1'b0);
        set(1, '0, 1'b0);
        #12;
        for (int g = 0; g < 2; g++) begin
            check("rst_state", g, {28'd0, x[g], x_valid[g], last[g], busy[g]}, 0);
        end
        @(posedge clk);
        #2 rst = 1'b0;

        // Directed: A5 MSB-first back-to-back with 3C; 01 LSB-first with gap.
        set(0, 8'hA5, 1'b1);
        set(1, 8'h01, 1'b1);
        tick();
        set(1, 8'hFF, 1'b0);
        for (int i = 1; i < 8; i++) begin
            set(0, 8'($urandom), 1'b1);
            tick();
        end
        set(0, 8'h3C, 1'b1);
        tick();
        set(0, 8'h00, 1'b0);
        repeat (20) tick();

        // Reset during bit 3 of a word, then a complete word afterwards.
        set(0, 8'h5A, 1'b1);
        set(1, 8'h96, 1'b1);
        tick();
        set(0, 8'h00, 1'b0);
        set(1, 8'h00, 1'b0);
        repeat (3) tick();
        #1 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check("async_rst_out", g, {29'd0, x[g], x_valid[g], busy[g]}, 0);
            check("async_rst_ready", g, 32'(din_ready[g]), 1);
        end
        @(posedge clk);
        #2 rst = 1'b0;
        set(0, 8'hC3, 1'b1);
        set(1, 8'h81, 1'b1);
        tick();
        set(0, 8'h00, 1'b0);
        set(1, 8'h00, 1'b0);
        repeat (14) tick();

        // Random traffic; din keeps changing while the block is busy.
        repeat (800) begin
            for (int g = 0; g < 2; g++) set(g, 8'($urandom), $urandom_range(0, 9) < 6);
            tick();
        end

        set(0, '0, 1'b0);
        set(1, '0, 1'b0);
        repeat (30) tick();
        check("drain", 0, g_dut[0].q.size(), 0);
        check("drain", 1, g_dut[1].q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/seq_serializer.md
SEQ_SERIALIZER -- requirements
Module: seq_serializer

Interface
REQ-001 SHALL have parameter WIDTH, default 8; bits per word, legal range 2..32.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = bit WIDTH-1 sent first, 0 = bit 0 sent first.
REQ-003 SHALL have parameter GAP, default 0; idle cycles inserted after each word, legal range 0..15.
REQ-004 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port din  input  WIDTH  parallel word to serialize.
REQ-007 SHALL have port din_valid  input  1  din holds a word to accept.
REQ-008 SHALL have port din_ready  output  1  block can accept a word this cycle.
REQ-009 SHALL have port x  output  1  serial bit, feeds the downstream sequence detector.
REQ-010 SHALL have port x_valid  output  1  x carries a data bit this cycle.
REQ-011 SHALL have port last  output  1  x carries the final bit of the current word.
REQ-012 SHALL have port busy  output  1  state is not IDLE.

Function
REQ-013 SHALL accept a word on a rising clk edge where din_valid=1 and din_ready=1, capturing din into an internal shift register.
REQ-014 SHALL ignore din and din_valid in every cycle where din_ready=0; no word is queued.
REQ-015 SHALL implement three states: IDLE, SHIFT, GAP.
REQ-016 SHALL transition IDLE->SHIFT on accept; otherwise remain in IDLE.
REQ-017 SHALL remain in SHIFT while bit counter < WIDTH-1, incrementing the counter each cycle.
REQ-018 SHALL leave SHIFT at counter = WIDTH-1: to GAP if GAP>0; else to SHIFT with a reloaded word on a same-edge accept; else to IDLE.
REQ-019 SHALL stay in GAP for exactly GAP cycles, then go to IDLE.
REQ-020 SHALL drive din_ready=1 in IDLE, and in SHIFT with counter = WIDTH-1 when GAP=0; 0 otherwise (combinational from state/counter).
REQ-021 SHALL make the first bit of an accepted word visible on x in the cycle immediately after the accept edge (latency 1).
REQ-022 SHALL assert x_valid for exactly WIDTH consecutive cycles per word, with bit order set by MSB_FIRST.
REQ-023 SHALL assert last only together with x_valid, on the WIDTH-th bit.
REQ-024 SHALL drive x=0 whenever x_valid=0.
REQ-025 SHALL, with GAP=0 and continuous din_valid, produce back-to-back words with no x_valid bubble.
REQ-026 SHALL size the bit counter at $clog2(WIDTH) bits and the gap counter at 4 bits, with no wrap beyond terminal values.
REQ-027 SHALL drive x, x_valid, last and busy from registers (no combinational path from din).

Reset
REQ-028 SHALL on rst=1 immediately force state=IDLE, counters=0, shift register=0, x=0, x_valid=0, last=0, busy=0, independent of clk.
REQ-029 SHALL abort any word in progress on reset, discard its remaining bits, and not resume that word after release.
REQ-030 SHALL drive din_ready=1 from the first rising edge after rst deasserts.

Structure
REQ-031 SHALL take state encoding constants (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10) from the shared package serial_pkg, which the sequence-detector stages also use.
REQ-032 SHALL remain a single module; no sub-module is required.

Verification
REQ-033 SHALL cover: MSB_FIRST=1, din=8'hA5 accepted -> x=1,0,1,0,0,1,0,1 over 8 cycles, x_valid high 8 cycles, last on cycle 8.
REQ-034 SHALL cover: MSB_FIRST=0, din=8'h01 -> x=1 then seven 0s, then x=0 with x_valid=0.
REQ-035 SHALL cover: GAP=0, 8'hA5 then 8'h3C with din_valid held -> 16 contiguous x_valid cycles, din_ready high only on bit 8 of the first word.
REQ-036 SHALL cover: GAP=2 -> after last, 2 cycles with x_valid=0 and din_ready=0, then din_ready=1.
REQ-037 SHALL cover: rst pulsed during bit 3 -> x, x_valid, busy go 0 without a clk edge; din_ready=1 after release; the next word is sent complete.
REQ-038 SHALL cover: din changing while busy with din_valid=1 -> output bits match the originally captured word only.
